pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: REG_ADDR_W, default 5, width of register-file addresses.
REQ-002 Parameter: CNT_W, default 16, width of each statistics counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 id_rs1, id_rs2  input  REG_ADDR_W each  source registers of the instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  input  1 each  the ID instruction actually reads that source.
REQ-007 ex_rd  input  REG_ADDR_W  destination register of the instruction in EX.
REQ-008 ex_mem_read  input  1  the instruction in EX is a load.
REQ-009 ex_branch_taken  input  1  the instruction in EX redirects the PC.
REQ-010 ex_mdu_start  input  1  the instruction in EX starts a multi-cycle multiply/divide.
REQ-011 mdu_done  input  1  the multiply/divide result is valid this cycle.
REQ-012 mem_req, mem_ready  input  1 each  data-memory request/ready handshake from MEM.
REQ-013 pc_en  output  1  PC update enable.
REQ-014 ifid_en, idex_en, exmem_en, memwb_en  output  1 each  pipeline-register enables.
REQ-015 ifid_clear, idex_clear, exmem_clear, memwb_clear  output  1 each  pipeline-register flush (bubble insertion).
REQ-016 stall_cnt, flush_cnt  output  CNT_W each  statistics counters.

Function
REQ-017 FSM states: RUN and MDU_BUSY; RUN -> MDU_BUSY when ex_mdu_start=1 in RUN with no memory stall; MDU_BUSY -> RUN on the edge where mdu_done=1; all other cases hold state.
REQ-018 mem_stall = mem_req & ~mem_ready, evaluated combinationally in any state.
REQ-019 load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-020 Priority 1 (mem_stall): all enables 0, all clears 0; no stage or PC advances; FSM holds.
REQ-021 Priority 2 (state MDU_BUSY, mdu_done=0): pc_en, ifid_en, idex_en 0; exmem_clear 1; memwb_en 1; other clears 0.
REQ-022 Priority 3 (ex_branch_taken, RUN): all enables 1; ifid_clear and idex_clear 1; overrides load_use.
REQ-023 Priority 4 (load_use, RUN): pc_en, ifid_en 0; idex_clear 1; exmem_en, memwb_en 1.
REQ-024 Otherwise (including MDU_BUSY with mdu_done=1): all enables 1, all clears 0.
REQ-025 Outputs pc_en/en/clear are combinational from state and inputs; zero-cycle latency from hazard input to control output.
REQ-026 stall_cnt increments by 1 on every cycle with pc_en=0 after reset; saturates at all-ones.
REQ-027 flush_cnt increments by 1 on every cycle where REQ-022 applies; saturates at all-ones.
REQ-028 ex_mdu_start and ex_branch_taken both 1 in RUN: branch flush applies this cycle and FSM still enters MDU_BUSY.
REQ-029 mdu_done while in RUN is ignored.

Reset
REQ-030 While rst=0: state RUN, stall_cnt=0, flush_cnt=0, all enables 0, all clears 0, independent of clock.
REQ-031 Reset asserted mid-MDU_BUSY or mid-memory-stall returns to RUN at once; first post-reset cycle obeys REQ-020..REQ-024 normally.

Structure
REQ-032 Shared package pipeline_pkg holds the FSM state enum and the default REG_ADDR_W/CNT_W constants.
REQ-033 One sub-module sat_counter (parameter WIDTH; inputs clk, rst, inc; output count) implements REQ-026/REQ-027, instantiated twice.

Verification
REQ-034 ex_mem_read=1, ex_rd=5, id_use_rs1=1, id_rs1=5 -> pc_en=0, ifid_en=0, idex_clear=1, stall_cnt +1.
REQ-035 Same as REQ-034 but ex_rd=0 -> no stall, all enables 1, all clears 0.
REQ-036 Load-use hazard plus ex_branch_taken=1 -> ifid_clear=1, idex_clear=1, pc_en=1, flush_cnt +1, stall_cnt unchanged.
REQ-037 ex_mdu_start=1, mdu_done after 4 cycles -> 4 cycles MDU_BUSY with exmem_clear=1, pc_en=0; RUN on the 5th; stall_cnt=4.
REQ-038 mem_req=1, mem_ready=0 for 3 cycles during MDU_BUSY -> all enables 0, all clears 0, FSM held, stall_cnt +3.
REQ-039 CNT_W=4, 20 stall cycles -> stall_cnt=15 and held; rst=0 mid-MDU_BUSY -> counters 0, state RUN immediately.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and default widths for the pipeline hazard/stall controller.
package pipeline_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MDU_BUSY = 1'b1
  } state_e;

  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: memory stalls, multi-cycle MDU stalls,
// branch flushes and load-use bubbles, plus stall/flush statistics.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_use_rs1,
  input  logic                  i_id_use_rs2,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_mem_read,
  input  logic                  i_ex_branch_taken,
  input  logic                  i_ex_mdu_start,
  input  logic                  i_mdu_done,
  input  logic                  i_mem_req,
  input  logic                  i_mem_ready,
  output logic                  o_pc_en,
  output logic                  o_ifid_en,
  output logic                  o_idex_en,
  output logic                  o_exmem_en,
  output logic                  o_memwb_en,
  output logic                  o_ifid_clear,
  output logic                  o_idex_clear,
  output logic                  o_exmem_clear,
  output logic                  o_memwb_clear,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [CNT_W-1:0]      o_flush_cnt
);

  state_e r_state;

  logic w_run;
  logic w_mem_stall;
  logic w_load_use;
  logic w_mdu_wait;
  logic w_flush;
  logic w_stall_inc;

  assign w_run       = (r_state == ST_RUN);
  assign w_mem_stall = i_mem_req & ~i_mem_ready;
  assign w_mdu_wait  = ~w_run & ~i_mdu_done;
  assign w_load_use  = i_ex_mem_read & (i_ex_rd != '0) &
                       ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd)) |
                        (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));

  always_comb begin
    o_pc_en       = 1'b0;
    o_ifid_en     = 1'b0;
    o_idex_en     = 1'b0;
    o_exmem_en    = 1'b0;
    o_memwb_en    = 1'b0;
    o_ifid_clear  = 1'b0;
    o_idex_clear  = 1'b0;
    o_exmem_clear = 1'b0;
    o_memwb_clear = 1'b0;
    w_flush       = 1'b0;
    // Reset and memory stall both freeze everything, so they share the all-zero default.
    if (rst_n && !w_mem_stall) begin
      if (w_mdu_wait) begin
        o_memwb_en    = 1'b1;
        o_exmem_clear = 1'b1;
      end else if (w_run && i_ex_branch_taken) begin
        o_pc_en      = 1'b1;
        o_ifid_en    = 1'b1;
        o_idex_en    = 1'b1;
        o_exmem_en   = 1'b1;
        o_memwb_en   = 1'b1;
        o_ifid_clear = 1'b1;
        o_idex_clear = 1'b1;
        w_flush      = 1'b1;
      end else if (w_run && w_load_use) begin
        // ID/EX loads the bubble, so its enable stays high alongside the clear.
        o_idex_en    = 1'b1;
        o_exmem_en   = 1'b1;
        o_memwb_en   = 1'b1;
        o_idex_clear = 1'b1;
      end else begin
        o_pc_en    = 1'b1;
        o_ifid_en  = 1'b1;
        o_idex_en  = 1'b1;
        o_exmem_en = 1'b1;
        o_memwb_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else if (!w_mem_stall) begin
      case (r_state)
        ST_RUN:      if (i_ex_mdu_start) r_state <= ST_MDU_BUSY;
        ST_MDU_BUSY: if (i_mdu_done)     r_state <= ST_RUN;
        default:                         r_state <= ST_RUN;
      endcase
    end
  end

  assign w_stall_inc = ~o_pc_en;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_stall_inc),
    .o_count (o_stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_flush),
    .o_count (o_flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard scenarios plus random traffic against a rule-table model.
module tb_pipeline_ctrl;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
  logic          ex_mdu_start, mdu_done, mem_req, mem_ready;

  logic a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ifid_c, a_idex_c, a_exmem_c, a_memwb_c;
  logic b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_ifid_c, b_idex_c, b_exmem_c, b_memwb_c;
  logic [15:0] a_stall, a_flush;
  logic [3:0]  b_stall, b_flush;

  wire [8:0] a_ctrl = {a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ifid_c, a_idex_c, a_exmem_c, a_memwb_c};
  wire [8:0] b_ctrl = {b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_ifid_c, b_idex_c, b_exmem_c, b_memwb_c};

  pipeline_ctrl #(.REG_ADDR_W(AW), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
    .i_ex_rd(ex_rd), .i_ex_mem_read(ex_mem_read), .i_ex_branch_taken(ex_branch_taken),
    .i_ex_mdu_start(ex_mdu_start), .i_mdu_done(mdu_done), .i_mem_req(mem_req), .i_mem_ready(mem_ready),
    .o_pc_en(a_pc), .o_ifid_en(a_ifid), .o_idex_en(a_idex), .o_exmem_en(a_exmem), .o_memwb_en(a_memwb),
    .o_ifid_clear(a_ifid_c), .o_idex_clear(a_idex_c), .o_exmem_clear(a_exmem_c), .o_memwb_clear(a_memwb_c),
    .o_stall_cnt(a_stall), .o_flush_cnt(a_flush));

  pipeline_ctrl #(.REG_ADDR_W(AW), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
    .i_ex_rd(ex_rd), .i_ex_mem_read(ex_mem_read), .i_ex_branch_taken(ex_branch_taken),
    .i_ex_mdu_start(ex_mdu_start), .i_mdu_done(mdu_done), .i_mem_req(mem_req), .i_mem_ready(mem_ready),
    .o_pc_en(b_pc), .o_ifid_en(b_ifid), .o_idex_en(b_idex), .o_exmem_en(b_exmem), .o_memwb_en(b_memwb),
    .o_ifid_clear(b_ifid_c), .o_idex_clear(b_idex_c), .o_exmem_clear(b_exmem_c), .o_memwb_clear(b_memwb_c),
    .o_stall_cnt(b_stall), .o_flush_cnt(b_flush));

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: "busy" means a multiply/divide is outstanding; counters are unbounded ints.
  bit m_busy  = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  // 0 freeze, 1 MDU wait, 2 branch flush, 3 load-use bubble, 4 normal flow
  function automatic int rule();
    bit hazard;
    hazard = ex_mem_read && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (!rst_n || (mem_req && !mem_ready)) return 0;
    if (m_busy && !mdu_done)               return 1;
    if (!m_busy && ex_branch_taken)        return 2;
    if (!m_busy && hazard)                 return 3;
    return 4;
  endfunction

  function automatic logic [8:0] ctrl_of(input int r);
    case (r)
      1:       return 9'b00001_0010;
      2:       return 9'b11111_1100;
      3:       return 9'b00111_0100;
      4:       return 9'b11111_0000;
      default: return 9'b00000_0000;
    endcase
  endfunction

  task automatic check_counts(input string tag);
    check({tag, ".a_stall"}, 32'(a_stall), 32'(sat(m_stall, 16)));
    check({tag, ".a_flush"}, 32'(a_flush), 32'(sat(m_flush, 16)));
    check({tag, ".b_stall"}, 32'(b_stall), 32'(sat(m_stall, 4)));
    check({tag, ".b_flush"}, 32'(b_flush), 32'(sat(m_flush, 4)));
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // One clock of traffic: outputs checked at the falling edge, counters just after the rising edge.
  task automatic step(input string tag);
    int r;
    logic [8:0] e;
    @(negedge clk);
    r = rule();
    e = ctrl_of(r);
    check({tag, ".a_ctrl"}, 32'(a_ctrl), 32'(e));
    check({tag, ".b_ctrl"}, 32'(b_ctrl), 32'(e));
    @(posedge clk);
    #1;
    if (e[8] == 1'b0) m_stall++;
    if (r == 2) m_flush++;
    if (r != 0) begin
      if (!m_busy && ex_mdu_start) m_busy = 1'b1;
      else if (m_busy && mdu_done) m_busy = 1'b0;
    end
    check_counts(tag);
    $display("step %-10s rule=%0d ctrl=%b stall=%0d flush=%0d busy=%0d", tag, r, a_ctrl, a_stall, a_flush, m_busy);
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0; ex_branch_taken = 0;
    ex_mdu_start = 0; mdu_done = 0; mem_req = 0; mem_ready = 1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset.a_ctrl", 32'(a_ctrl), 32'd0);
    check("reset.b_ctrl", 32'(b_ctrl), 32'd0);
    check_counts("reset");
    rst_n = 1'b1;

    // Load-use on rs1
    idle(); ex_mem_read = 1; ex_rd = 5; id_use_rs1 = 1; id_rs1 = 5;
    step("loaduse");
    // Same but destination x0: no hazard
    ex_rd = 0; id_rs1 = 0;
    step("rd_zero");
    // Load-use on rs2 combined with a taken branch: flush wins
    idle(); ex_mem_read = 1; ex_rd = 7; id_use_rs2 = 1; id_rs2 = 7; ex_branch_taken = 1;
    step("br_lu");
    idle(); step("normal");

    // MDU: start, four busy cycles, done on the fifth
    idle(); ex_mdu_start = 1; step("mdu_start");
    idle();
    for (int i = 0; i < 4; i++) step("mdu_wait");
    mdu_done = 1; step("mdu_done");
    idle(); mdu_done = 1; step("done_run");

    // Memory stall for three cycles while the MDU is busy
    idle(); ex_mdu_start = 1; ex_branch_taken = 1; step("mdu_br");
    idle(); mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) step("memstall");
    mdu_done = 1; step("stall_done");
    idle(); mdu_done = 1; step("mdu_exit");
    idle(); step("normal2");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      id_rs1          = AW'($urandom_range(0, 3));
      id_rs2          = AW'($urandom_range(0, 3));
      ex_rd           = AW'($urandom_range(0, 3));
      id_use_rs1      = 1'($urandom_range(0, 1));
      id_use_rs2      = 1'($urandom_range(0, 1));
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      ex_mdu_start    = ($urandom_range(0, 7) == 0);
      mdu_done        = ($urandom_range(0, 3) == 0);
      mem_req         = ($urandom_range(0, 3) == 0);
      mem_ready       = 1'($urandom_range(0, 1));
      step("random");
    end

    // Reset asserted in the middle of an MDU operation
    idle(); ex_mdu_start = 1; step("pre_rst");
    idle(); step("busy_rst");
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst.a_ctrl", 32'(a_ctrl), 32'd0);
    check("midrst.b_ctrl", 32'(b_ctrl), 32'd0);
    check_counts("midrst");
    rst_n = 1'b1;
    idle(); step("post_rst");

    // Twenty load-use stalls: the 4-bit counter must stop at 15
    idle(); ex_mem_read = 1; ex_rd = 3; id_use_rs2 = 1; id_rs2 = 3;
    for (int i = 0; i < 20; i++) step("sat");
    check("sat.b_stall_max", 32'(b_stall), 32'd15);
    check("sat.a_stall_20", 32'(a_stall), 32'd20);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
